// File: rtl/elastic_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elastic_delay_pkg
// Purpose  : Shared types and helpers for the elastic delay buffer.
//            - state_t : control state of the buffer (idle / busy / flush)
//            - edb_cw  : width of the occupancy counter for a given DEPTH/LAT
// Revision : 1.0 - initial release
// ============================================================================
package elastic_delay_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Occupancy counter width: large enough for DEPTH stored words plus
    // LAT words in flight, with headroom.
    function automatic int edb_cw(input int depth, input int lat);
        return $clog2(depth + lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_delay_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : elastic_delay_buf_if
// Purpose  : Push/read handshake bundle of the elastic delay buffer.
//            i_en / i_d       : push strobe and data (no backpressure)
//            i_rd_ready       : consumer ready
//            o_valid / o_q    : head word available / head word
//            Modport slave  : buffer side.
//            Modport master : producer/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface elastic_delay_buf_if #(
    parameter int BITS = 8
);
    logic            i_en;
    logic [BITS-1:0] i_d;
    logic            i_rd_ready;
    logic            o_valid;
    logic [BITS-1:0] o_q;

    modport slave (
        input  i_en,
        input  i_d,
        input  i_rd_ready,
        output o_valid,
        output o_q
    );

    modport master (
        output i_en,
        output i_d,
        output i_rd_ready,
        input  o_valid,
        input  o_q
    );
endinterface
`default_nettype wire

// File: rtl/elastic_delay_buf_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : valid_pipe
// Purpose  : LAT-stage valid+data shift register. Advances every cycle (no
//            enable); i_clr synchronously drops every in-flight valid.
// Ports    : i_clk        clock
//            i_clr        synchronous clear of all stage valids
//            i_v / i_d    stage-0 input valid/data
//            o_v / o_d    last-stage valid/data
// Revision : 1.0 - initial release
// ============================================================================
module valid_pipe #(
    parameter int LAT  = 2,
    parameter int BITS = 8
) (
    input  wire logic            i_clk,
    input  wire logic            i_clr,
    input  wire logic            i_v,
    input  wire logic [BITS-1:0] i_d,
    output logic                 o_v,
    output logic [BITS-1:0]      o_d
);

    logic            r_v [LAT];
    logic [BITS-1:0] r_d [LAT];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < LAT; i++) begin
                r_v[i] <= 1'b0;
            end
        end else begin
            r_v[0] <= i_v;
            for (int i = 1; i < LAT; i++) begin
                r_v[i] <= r_v[i-1];
            end
        end
    end

    // Data is qualified by the valid bits, so it needs no clear.
    always_ff @(posedge i_clk) begin
        r_d[0] <= i_d;
        for (int i = 1; i < LAT; i++) begin
            r_d[i] <= r_d[i-1];
        end
    end

    assign o_v = r_v[LAT-1];
    assign o_d = r_d[LAT-1];

endmodule
`default_nettype wire

// File: rtl/elastic_delay_buf.sv
`default_nettype none
// ============================================================================
// Module   : elastic_delay_buf
// Purpose  : Words pushed on i_en are delayed LAT cycles through valid_pipe,
//            then stored in a DEPTH-entry FIFO and presented on a valid/ready
//            read port. No push backpressure: pushes that find the buffer full
//            (and no pop in the same cycle) are dropped and flagged sticky in
//            o_overflow.
// Ports    : i_clk, i_rst_n (sync, active low), i_flush (discard everything)
//            bus (slave)  : i_en, i_d, i_rd_ready, o_valid, o_q
//            o_count      : words accepted but not yet popped
//            o_full/o_empty, o_overflow (sticky)
//            o_peak       : high-water mark of o_count, only when
//                           ELASTIC_DELAY_BUF_PEAK_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module elastic_delay_buf
    import elastic_delay_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  BITS  = 8,
    parameter int  LAT   = 2,
    localparam int CW    = edb_cw(DEPTH, LAT)
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    input  wire logic           i_flush,
    elastic_delay_buf_if.slave  bus,
    output logic [CW-1:0]       o_count,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_overflow
`ifdef ELASTIC_DELAY_BUF_PEAK_EN
    ,
    output logic [CW-1:0]       o_peak
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_overflow;
    // Pointers carry one extra wrap bit so full and empty FIFOs differ.
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [BITS-1:0] r_mem [DEPTH];

    logic            w_in_flush;
    logic            w_clear;
    logic            w_fifo_nempty;
    logic            w_valid;
    logic            w_pop;
    logic            w_push_acc;
    logic            w_drop;
    logic            w_pipe_v;
    logic [BITS-1:0] w_pipe_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_flush    = (r_state == S_FLUSH);
        w_clear       = i_flush || w_in_flush;
        w_fifo_nempty = (r_wr_ptr != r_rd_ptr);
        w_valid       = w_fifo_nempty && !w_in_flush;
        w_pop         = w_valid && bus.i_rd_ready;
        // A pop in the same cycle frees a slot, so a full buffer still accepts.
        w_push_acc    = bus.i_en && !w_in_flush && (!o_full || w_pop);
        w_drop        = bus.i_en && !w_in_flush && o_full && !w_pop;
        if (w_clear) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_push_acc) - CW'(w_pop);
        end
    end

    assign bus.o_valid = w_valid;
    assign bus.o_q     = w_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign o_count     = r_count;
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_overflow  = r_overflow;

    // ------------------------------------------------------------------------
    // Latency pipeline. Only accepted pushes enter; because o_count already
    // includes in-flight words, every word leaving the pipe has a FIFO slot.
    // ------------------------------------------------------------------------
    valid_pipe #(
        .LAT  (LAT),
        .BITS (BITS)
    ) u_valid_pipe (
        .i_clk (i_clk),
        .i_clr (!i_rst_n || w_clear),
        .i_v   (w_push_acc && !i_flush),
        .i_d   (bus.i_d),
        .o_v   (w_pipe_v),
        .o_d   (w_pipe_d)
    );

    // ------------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow flag
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pipe_v) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; entries are only read once their pointer is valid.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && !w_clear && w_pipe_v) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_pipe_d;
        end
    end

    // ------------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE:  if (w_push_acc) w_state_nxt = S_BUSY;
                S_BUSY:  if (w_count_nxt == '0) w_state_nxt = S_IDLE;
                S_FLUSH: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef ELASTIC_DELAY_BUF_PEAK_EN
    logic [CW-1:0] r_peak;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end

    assign o_peak = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_delay_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_delay_buf
// Purpose  : Directed bench for elastic_delay_buf (DEPTH=8, BITS=8, LAT=2).
//            Stimulus pushes expected words into a scoreboard queue; a monitor
//            on the falling edge pops and compares on every read handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_delay_buf;

    localparam int DEPTH = 8;
    localparam int BITS  = 8;
    localparam int LAT   = 2;
    localparam int CW    = $clog2(DEPTH + LAT + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
`ifdef ELASTIC_DELAY_BUF_PEAK_EN
    logic [CW-1:0] peak;
`endif

    always #5 clk = ~clk;

    elastic_delay_buf_if #(.BITS(BITS)) bus ();

    elastic_delay_buf #(
        .DEPTH (DEPTH),
        .BITS  (BITS),
        .LAT   (LAT)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .bus        (bus),
        .o_count    (count),
        .o_full     (full),
        .o_empty    (empty),
        .o_overflow (ovf)
`ifdef ELASTIC_DELAY_BUF_PEAK_EN
        ,
        .o_peak     (peak)
`endif
    );

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [BITS-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push; the word joins the scoreboard only if it should survive.
    task automatic push(input logic [BITS-1:0] d, input bit expect_kept);
        bus.i_en = 1'b1;
        bus.i_d  = d;
        if (expect_kept) exp_q.push_back(d);
        tick();
        bus.i_en = 1'b0;
    endtask

    // Scoreboard monitor: any handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !flush && bus.o_valid && bus.i_rd_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h, required no word", bus.o_q);
            end else begin
                chk("pop_data", 32'(bus.o_q), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.i_en       = 1'b0;
        bus.i_d        = '0;
        bus.i_rd_ready = 1'b0;
        tick();
        tick();

        // ---------------- reset values ----------------
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_q",     32'(bus.o_q),     32'd0);
        chk("rst_count", 32'(count),       32'd0);
        chk("rst_empty", 32'(empty),       32'd1);
        chk("rst_full",  32'(full),        32'd0);
        chk("rst_ovf",   32'(ovf),         32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- latency ----------------
        bus.i_rd_ready = 1'b1;
        push(8'hA5, 1'b1);                       // edge 0
        chk("lat_count_e0", 32'(count),     32'd1);
        chk("lat_valid_e0", 32'(bus.o_valid), 32'd0);
        tick();                                  // edge 1
        chk("lat_valid_e1", 32'(bus.o_valid), 32'd0);
        tick();                                  // edge 2
        chk("lat_valid_e2", 32'(bus.o_valid), 32'd1);
        chk("lat_q_e2",     32'(bus.o_q),     32'hA5);
        tick();                                  // edge 3
        chk("lat_valid_e3", 32'(bus.o_valid), 32'd0);
        chk("lat_count_e3", 32'(count),       32'd0);
        chk("lat_empty_e3", 32'(empty),       32'd1);

        // ---------------- backpressure fill ----------------
        bus.i_rd_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
        tick();
        tick();
        chk("bp_full",  32'(full),        32'd1);
        chk("bp_count", 32'(count),       32'd8);
        chk("bp_valid", 32'(bus.o_valid), 32'd1);
        chk("bp_head",  32'(bus.o_q),     32'h01);

        // ---------------- full with simultaneous pop ----------------
        bus.i_rd_ready = 1'b1;
        push(8'h10, 1'b1);
        bus.i_rd_ready = 1'b0;
        chk("fp_count", 32'(count), 32'd8);
        chk("fp_ovf",   32'(ovf),   32'd0);

        // ---------------- overflow ----------------
        push(8'h99, 1'b0);
        chk("ovf_flag",  32'(ovf),   32'd1);
        chk("ovf_count", 32'(count), 32'd8);

        // ---------------- drain ----------------
        bus.i_rd_ready = 1'b1;
        for (int i = 0; i < 40 && !empty; i++) tick();
        chk("drain_empty",  32'(empty),        32'd1);
        chk("drain_count",  32'(count),        32'd0);
        chk("drain_left",   32'(exp_q.size()), 32'd0);
        chk("drain_ovf",    32'(ovf),          32'd1);

        // ---------------- flush mid-stream ----------------
        bus.i_rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 1'b1);
        tick();
        tick();
        push(8'h25, 1'b1);
        push(8'h26, 1'b1);
        chk("fl_count_pre", 32'(count), 32'd7);
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(bus.o_valid), 32'd0);
        chk("fl_count", 32'(count),       32'd0);
        chk("fl_ovf",   32'(ovf),         32'd0);
        push(8'h77, 1'b0);                       // lands in the flush cycle
        chk("fl_ign_count", 32'(count), 32'd0);
        chk("fl_ign_ovf",   32'(ovf),   32'd0);
        bus.i_rd_ready = 1'b1;
        repeat (6) tick();
        chk("fl_post_count", 32'(count),       32'd0);
        chk("fl_post_valid", 32'(bus.o_valid), 32'd0);

        // ---------------- reset mid-stream ----------------
        bus.i_rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(8'h31 + i), 1'b1);
        tick();
        tick();
        chk("mr_count_pre", 32'(count),       32'd3);
        chk("mr_valid_pre", 32'(bus.o_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        chk("mr_valid", 32'(bus.o_valid), 32'd0);
        chk("mr_q",     32'(bus.o_q),     32'd0);
        chk("mr_count", 32'(count),       32'd0);
        chk("mr_empty", 32'(empty),       32'd1);
        chk("mr_full",  32'(full),        32'd0);
        chk("mr_ovf",   32'(ovf),         32'd0);
        bus.i_rd_ready = 1'b1;
        push(8'h3C, 1'b1);                       // edge 0
        tick();                                  // edge 1
        chk("mr_new_valid_e1", 32'(bus.o_valid), 32'd0);
        tick();                                  // edge 2
        chk("mr_new_valid_e2", 32'(bus.o_valid), 32'd1);
        chk("mr_new_q_e2",     32'(bus.o_q),     32'h3C);
        repeat (4) tick();
        chk("mr_end_count", 32'(count),        32'd0);
        chk("mr_end_left",  32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
